// File: rtl/adat_rx_frame_buffer.sv
// rtl/adat_rx_frame_buffer.sv - assembles parser channel words into atomic 8-channel ADAT frames
//
// Collects ch0..ch7 words from the frame parser into a shadow store and
// publishes the whole frame in one cycle when ch7 arrives in order.
// Out-of-order words, aborted partial frames and sync loss raise a
// one-cycle error strobe. A lock flag asserts after LOCK_FRAMES
// consecutive good frames.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_user         user nibble, meaningful alongside channel 0
//   i_data         24-bit sample word
//   i_channel      channel index of i_data
//   i_data_valid   one-cycle strobe qualifying i_data/i_channel
//   i_sync         upstream sync; low means the stream is invalid
//   o_frame_data   last complete frame, channel k at [24*k +: 24]
//   o_user         user nibble of the frame in o_frame_data
//   o_frame_valid  one-cycle strobe: new frame presented
//   o_frame_error  one-cycle strobe: partial/out-of-order frame discarded
//   o_locked       stream locked
//   o_frame_count  wrapping count of good frames
module adat_rx_frame_buffer #(
  parameter int LOCK_FRAMES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_user,
  input  logic [23:0]            i_data,
  input  logic [2:0]             i_channel,
  input  logic                   i_data_valid,
  input  logic                   i_sync,
  output logic [191:0]           o_frame_data,
  output logic [3:0]             o_user,
  output logic                   o_frame_valid,
  output logic                   o_frame_error,
  output logic                   o_locked,
  output logic [COUNT_WIDTH-1:0] o_frame_count
);

  localparam logic [3:0] LOCK_TARGET = LOCK_FRAMES[3:0];

  logic [23:0] shadow [7];
  logic [3:0]  shadow_user;
  logic [2:0]  exp;
  logic [3:0]  good;
  logic [3:0]  good_inc;
  logic        busy;

  assign busy = (exp != 3'd0);

  // Saturating lock counter value for when a frame completes.
  always_comb begin
    good_inc = good;
    if (good >= LOCK_TARGET) good_inc = LOCK_TARGET;
    else                     good_inc = good + 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 7; k++) shadow[k] <= '0;
      shadow_user   <= '0;
      exp           <= '0;
      good          <= '0;
      o_frame_data  <= '0;
      o_user        <= '0;
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
      o_locked      <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
      if (!i_sync) begin
        // Sync loss wins over any word strobed in the same cycle.
        exp           <= '0;
        good          <= '0;
        o_locked      <= 1'b0;
        o_frame_error <= busy;
      end else if (i_data_valid) begin
        if (i_channel == exp) begin
          if (exp == 3'd7) begin
            for (int k = 0; k < 7; k++) o_frame_data[24*k +: 24] <= shadow[k];
            o_frame_data[24*7 +: 24] <= i_data;
            o_user        <= shadow_user;
            o_frame_valid <= 1'b1;
            o_frame_count <= o_frame_count + 1'b1;
            exp           <= '0;
            good          <= good_inc;
            o_locked      <= (good_inc == LOCK_TARGET);
          end else begin
            shadow[exp] <= i_data;
            if (exp == 3'd0) shadow_user <= i_user;
            exp <= exp + 3'd1;
          end
        end else begin
          o_frame_error <= 1'b1;
          good          <= '0;
          o_locked      <= 1'b0;
          if (i_channel == 3'd0) begin
            // A fresh ch0 aborts the partial frame and starts a new one.
            shadow[0]   <= i_data;
            shadow_user <= i_user;
            exp         <= 3'd1;
          end else begin
            exp <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adat_rx_frame_buffer.sv
// tb/tb_adat_rx_frame_buffer.sv - scoreboard bench for adat_rx_frame_buffer
module tb_adat_rx_frame_buffer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [3:0]   i_user;
  logic [23:0]  i_data;
  logic [2:0]   i_channel;
  logic         i_data_valid;
  logic         i_sync;
  logic [191:0] o_frame_data;
  logic [3:0]   o_user;
  logic         o_frame_valid;
  logic         o_frame_error;
  logic         o_locked;
  logic [15:0]  o_frame_count;

  adat_rx_frame_buffer #(.LOCK_FRAMES(2), .COUNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_user(i_user), .i_data(i_data),
    .i_channel(i_channel), .i_data_valid(i_data_valid), .i_sync(i_sync),
    .o_frame_data(o_frame_data), .o_user(o_user), .o_frame_valid(o_frame_valid),
    .o_frame_error(o_frame_error), .o_locked(o_locked), .o_frame_count(o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit           is_err;
    logic [191:0] data;
    logic [3:0]   user;
    logic [15:0]  count;
    logic         locked;
  } ev_t;

  ev_t         sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [23:0] cur [8];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [191:0] pack_cur();
    logic [191:0] f;
    for (int k = 0; k < 8; k++) f[24*k +: 24] = cur[k];
    return f;
  endfunction

  task automatic push_frame(input logic [3:0] user, input logic [15:0] count, input logic locked);
    ev_t e;
    e.is_err = 1'b0; e.data = pack_cur(); e.user = user; e.count = count; e.locked = locked;
    sb.push_back(e);
  endtask

  task automatic push_error();
    ev_t e;
    e.is_err = 1'b1; e.data = '0; e.user = '0; e.count = '0; e.locked = 1'b0;
    sb.push_back(e);
  endtask

  // Inputs change #1 after a rising edge; one strobe occupies one cycle.
  task automatic send(input logic [2:0] ch, input logic [23:0] d, input logic [3:0] user, input int gap);
    i_channel = ch; i_data = d; i_user = user; i_data_valid = 1'b1;
    @(posedge i_clk); #1;
    i_data_valid = 1'b0;
    repeat (gap) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_range(input int first, input int last, input logic [3:0] user, input int gap);
    for (int k = first; k <= last; k++) send(3'(k), cur[k], user, gap);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 8; k++) cur[k] = 24'($urandom);
  endtask

  // Scoreboard consumer: every strobe must match the next expected event.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_frame_valid && o_frame_error) check("valid_and_error_together", 1'b1, 1'b0);
      if (o_frame_valid || o_frame_error) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {o_frame_valid, o_frame_error}, 2'b00);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("event_kind_is_error", o_frame_error, e.is_err);
          if (e.is_err) begin
            check("locked_after_error", o_locked, 1'b0);
          end else begin
            check("frame_data", o_frame_data, e.data);
            check("frame_user", o_user, e.user);
            check("frame_count", o_frame_count, e.count);
            check("frame_locked", o_locked, e.locked);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [191:0] held;

  initial begin
    i_rst = 1'b1; i_sync = 1'b0; i_user = '0; i_data = '0; i_channel = '0; i_data_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_frame_data", o_frame_data, '0);
    check("reset_user", o_user, 4'h0);
    check("reset_valid", o_frame_valid, 1'b0);
    check("reset_error", o_frame_error, 1'b0);
    check("reset_locked", o_locked, 1'b0);
    check("reset_count", o_frame_count, 16'd0);
    i_rst = 1'b0; i_sync = 1'b1;
    @(posedge i_clk); #1;

    // Basic frame: data k, user 1010, one strobe every 6 cycles.
    for (int k = 0; k < 8; k++) cur[k] = 24'(k);
    push_frame(4'b1010, 16'd1, 1'b0);
    send_range(0, 7, 4'b1010, 5);
    check("basic_count", o_frame_count, 16'd1);
    check("basic_locked", o_locked, 1'b0);

    // Lock: two more good frames of all-ones; lock rises on the second overall.
    for (int k = 0; k < 8; k++) cur[k] = 24'hFFFFFF;
    push_frame(4'h5, 16'd2, 1'b1);
    send_range(0, 7, 4'h5, 2);
    push_frame(4'h5, 16'd3, 1'b1);
    send_range(0, 7, 4'h5, 2);
    check("lock_locked", o_locked, 1'b1);
    check("lock_count", o_frame_count, 16'd3);

    // Skip: ch0, ch1, ch3 -> error after ch3, outputs held.
    held = o_frame_data;
    push_error();
    send(3'd0, 24'h111111, 4'h3, 1);
    send(3'd1, 24'h222222, 4'h3, 1);
    send(3'd3, 24'h333333, 4'h3, 1);
    check("skip_locked", o_locked, 1'b0);
    check("skip_data_held", o_frame_data, held);
    fill_random();
    push_frame(4'hC, 16'd4, 1'b0);
    send_range(0, 7, 4'hC, 1);

    // Restart: ch0..4 then a full ch0..7; only the second sequence is published.
    held = o_frame_data;
    fill_random();
    send_range(0, 4, 4'h6, 1);
    check("restart_held_partial", o_frame_data, held);
    fill_random();
    push_error();
    send_range(0, 6, 4'h9, 1);
    check("restart_held_before_ch7", o_frame_data, held);
    push_frame(4'h9, 16'd5, 1'b0);
    send_range(7, 7, 4'h9, 1);

    // Sync loss with a simultaneous ch6 strobe, low for 3 cycles.
    held = o_frame_data;
    fill_random();
    send_range(0, 5, 4'h2, 1);
    push_error();
    i_sync = 1'b0;
    send(3'd6, cur[6], 4'h2, 2);
    check("sync_locked", o_locked, 1'b0);
    check("sync_data_held", o_frame_data, held);
    i_sync = 1'b1;
    fill_random();
    push_frame(4'h7, 16'd6, 1'b0);
    send_range(0, 7, 4'h7, 1);
    // Back-to-back strobes with no gap re-establish lock.
    fill_random();
    push_frame(4'hE, 16'd7, 1'b1);
    send_range(0, 7, 4'hE, 0);
    repeat (2) @(posedge i_clk);
    #1;
    check("b2b_locked", o_locked, 1'b1);

    // Reset mid-frame after ch3.
    fill_random();
    send_range(0, 3, 4'h4, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("midrst_frame_data", o_frame_data, '0);
    check("midrst_user", o_user, 4'h0);
    check("midrst_error", o_frame_error, 1'b0);
    check("midrst_count", o_frame_count, 16'd0);
    check("midrst_locked", o_locked, 1'b0);
    // Continuing at ch4 is out of order; every remaining word is rejected.
    for (int k = 4; k <= 7; k++) push_error();
    send_range(4, 7, 4'h4, 1);
    check("midrst_no_frame_count", o_frame_count, 16'd0);

    repeat (4) @(posedge i_clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
